// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, fetches over req/ack,
// holds the word for decode and halts on misalign or bus timeout.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        advance,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic [6:0]  opcode,
  output logic        instr_valid,
  output logic        misalign,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    START,
    FETCH,
    HOLD,
    HALT
  } state_t;

  localparam logic [7:0] TMO = TIMEOUT[7:0];

  state_t      state;
  logic [7:0]  wait_cnt;
  logic [7:0]  wait_nxt;
  logic [31:0] next_pc;
  logic        accept;

  // next-PC selection and wait-count lookahead
  always_comb begin
    wait_nxt = wait_cnt + 8'd1;
    next_pc  = branch_taken ? branch_target : pc + 32'd4;
    accept   = advance & ~stall;
  end

  assign imem_addr = pc;
  assign opcode    = instr_valid ? instr[6:0] : 7'b000_0000;

  // fetch FSM with all outputs registered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= START;
      pc          <= RESET_PC;
      instr       <= 32'd0;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
      misalign    <= 1'b0;
      bus_err     <= 1'b0;
      wait_cnt    <= 8'd0;
    end else begin
      unique case (state)
        START: begin
          imem_req <= 1'b1;
          wait_cnt <= 8'd0;
          state    <= FETCH;
        end
        FETCH: begin
          if (imem_ack) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
            wait_cnt    <= 8'd0;
            state       <= HOLD;
          end else if (wait_nxt == TMO) begin
            bus_err  <= 1'b1;
            imem_req <= 1'b0;
            state    <= HALT;
          end else begin
            wait_cnt <= wait_nxt;
          end
        end
        HOLD: begin
          if (accept) begin
            instr_valid <= 1'b0;
            if (next_pc[1:0] != 2'b00) begin
              misalign <= 1'b1;
              state    <= HALT;
            end else begin
              pc       <= next_pc;
              imem_req <= 1'b1;
              wait_cnt <= 8'd0;
              state    <= FETCH;
            end
          end
        end
        HALT: begin
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
        default: state <= HALT;
      endcase
    end
  end

endmodule
